// File: rtl/clock_reset_pkg.sv
// clock_reset_pkg: shared types and constants for clock_reset_seq.
//   state_t     reset sequencer states (wait for lock, hold, run)
//   PH_*        phase-counter decode points for the clock-enable strobes
//   TURBO_*     CPU speed select encodings (used when CRS_TURBO_EN is defined)
package clock_reset_pkg;
    typedef enum logic [1:0] {ST_WAIT, ST_HOLD, ST_RUN} state_t;
    localparam logic [1:0] PH_CE14    = 2'd3;
    localparam logic [2:0] PH_PE7     = 3'd3;
    localparam logic [2:0] PH_NE7     = 3'd7;
    localparam logic [3:0] PH_PCPU    = 4'd7;
    localparam logic [3:0] PH_NCPU    = 4'd15;
    localparam logic [2:0] PH_PCPU7   = 3'd7;
    localparam logic [2:0] PH_NCPU7   = 3'd3;
    localparam logic [1:0] PH_PCPU14  = 2'd3;
    localparam logic [1:0] PH_NCPU14  = 2'd1;
    localparam logic [1:0] TURBO_3M5  = 2'b00;
    localparam logic [1:0] TURBO_7M   = 2'b01;
endpackage

// File: rtl/clock_reset_seq_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-low clear.
//   clock  in   destination clock
//   reset  in   asynchronous active-low clear
//   d      in   asynchronous input
//   q      out  synchronised output (2-cycle latency)
module sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/clock_reset_seq.sv
// clock_reset_seq: stretched system reset after MMCM lock plus ZX clock-enable strobes.
//   clock     in   56 MHz MMCM clock
//   reset     in   asynchronous active-low reset
//   locked    in   MMCM LOCKED (asynchronous)
//   stall     in   CPU contention, drops pcpu/ncpu
//   turbo     in   CPU speed select (only when CRS_TURBO_EN is defined)
//   sysrst_n  out  active-low system reset, high once running
//   ce14      out  14 MHz strobe
//   pe7/ne7   out  7 MHz pixel rising/falling strobes
//   pcpu/ncpu out  CPU rising/falling strobes (3.5 MHz unless turbo)
// Build option: CRS_TURBO_EN adds the turbo port and selectable CPU decode.
module clock_reset_seq
    import clock_reset_pkg::*;
#(
    parameter int HOLD   = 1024,
    parameter int HOLD_W = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       stall,
`ifdef CRS_TURBO_EN
    input  logic [1:0] turbo,
`endif
    output logic       sysrst_n,
    output logic       ce14,
    output logic       pe7,
    output logic       ne7,
    output logic       pcpu,
    output logic       ncpu
);
    state_t            state, state_nx;
    logic [HOLD_W-1:0] cnt, cnt_nx;
    logic [3:0]        ph;
    logic              lk_s, run, pc_hit, nc_hit;

    sync2 u_sync (.clock(clock), .reset(reset), .d(locked), .q(lk_s));

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        if (!lk_s) begin
            state_nx = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: state_nx = ST_HOLD;
                ST_HOLD: begin
                    cnt_nx   = cnt + 1'b1;
                    state_nx = (cnt == HOLD_W'(HOLD - 1)) ? ST_RUN : ST_HOLD;
                end
                default: state_nx = ST_RUN;
            endcase
        end
    end

    // Running also requires lk_s so a lock loss silences strobes on the very next edge.
    assign run = (state == ST_RUN) && lk_s;

`ifdef CRS_TURBO_EN
    assign pc_hit = (turbo == TURBO_3M5) ? (ph == PH_PCPU) :
                    (turbo == TURBO_7M)  ? (ph[2:0] == PH_PCPU7) : (ph[1:0] == PH_PCPU14);
    assign nc_hit = (turbo == TURBO_3M5) ? (ph == PH_NCPU) :
                    (turbo == TURBO_7M)  ? (ph[2:0] == PH_NCPU7) : (ph[1:0] == PH_NCPU14);
`else
    assign pc_hit = (ph == PH_PCPU);
    assign nc_hit = (ph == PH_NCPU);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_WAIT;
            cnt      <= '0;
            ph       <= '0;
            sysrst_n <= 1'b0;
            ce14     <= 1'b0;
            pe7      <= 1'b0;
            ne7      <= 1'b0;
            pcpu     <= 1'b0;
            ncpu     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            ph       <= run ? ph + 4'd1 : 4'd0;
            sysrst_n <= run;
            ce14     <= run && (ph[1:0] == PH_CE14);
            pe7      <= run && (ph[2:0] == PH_PE7);
            ne7      <= run && (ph[2:0] == PH_NE7);
            pcpu     <= run && pc_hit && !stall;
            ncpu     <= run && nc_hit && !stall;
        end
    end
endmodule

// File: tb/tb_clock_reset_seq.sv
// tb_clock_reset_seq: randomized self-checking bench for clock_reset_seq.
module tb_clock_reset_seq;
    localparam int HOLD = 1024;
    localparam int RISE = HOLD + 4;

    logic       clk = 1'b0;
    logic       reset, locked, stall;
    logic [1:0] turbo;
    logic       sysrst_n, ce14, pe7, ne7, pcpu, ncpu;

    int         total = 0;
    int         bad = 0;
    logic [5:0] exp;
    int         b = 0;
    int         t_now = -1;
    int         lk_q[$];

    always #5 clk = ~clk;

    clock_reset_seq #(.HOLD(HOLD), .HOLD_W(11)) dut (
        .clock(clk), .reset(reset), .locked(locked), .stall(stall),
`ifdef CRS_TURBO_EN
        .turbo(turbo),
`endif
        .sysrst_n(sysrst_n), .ce14(ce14), .pe7(pe7), .ne7(ne7), .pcpu(pcpu), .ncpu(ncpu)
    );

    // Reference: sysrst_n is up once locked has been seen high HOLD+4 edges in a row
    // (2 sync + 1 enter hold + HOLD count + 1 register); t counts edges since then.
    task automatic step(input logic lk, input logic st, input logic [1:0] tu);
        int per, pc, nc;
        logic up;
        locked = lk;
        stall  = st;
        turbo  = tu;
        @(posedge clk);
        lk_q.push_back(int'(lk));
        if (lk_q.size() > 3) void'(lk_q.pop_front());
        b = (lk_q.size() == 3 && lk_q[0] == 1) ? b + 1 : 0;
        up = (b >= HOLD + 2);
        t_now = up ? b - (HOLD + 2) : -1;
`ifdef CRS_TURBO_EN
        per = (tu == 2'b00) ? 16 : (tu == 2'b01) ? 8 : 4;
`else
        per = 16;
`endif
        pc = (per == 16) ? 7 : per - 1;
        nc = (per == 16) ? 15 : per / 2 - 1;
        exp = {up, up && t_now % 4 == 3, up && t_now % 8 == 3, up && t_now % 8 == 7,
               up && !st && t_now % per == pc, up && !st && t_now % per == nc};
        #1;
    endtask

    task automatic model_clear();
        lk_q.delete();
        b = 0;
        t_now = -1;
        exp = '0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0; locked = 1'b1; stall = 1'b0; turbo = 2'b00;
        model_clear();
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== 6'b0) begin
                bad++; $display("FAIL reset_outputs got=%b exp=000000", {sysrst_n, ce14, pe7, ne7, pcpu, ncpu});
            end
        end
        #2 reset = 1'b1;
        n = 0;
        for (int i = 1; i <= RISE + 20 && n == 0; i++) begin
            step(1'b1, 1'b0, 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL reset_seq cyc=%0d got=%b exp=%b", i, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
            if (sysrst_n === 1'b1) n = i;
        end
        total++;
        if (n != RISE) begin
            bad++; $display("FAIL reset_rise_cycle got=%0d exp=%0d", n, RISE);
        end
    endtask

    task automatic test_run();
        int c14, cp7, cn7, cpc, cnc;
        c14 = 0; cp7 = 0; cn7 = 0; cpc = 0; cnc = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 1'b0, 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL run t=%0d got=%b exp=%b", t_now, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
            total++;
            if ((pe7 && ne7) || (pcpu && ncpu) || (pcpu && !ne7)) begin
                bad++; $display("FAIL run_coincide t=%0d pe7=%b ne7=%b pcpu=%b ncpu=%b", t_now, pe7, ne7, pcpu, ncpu);
            end
            c14 += int'(ce14); cp7 += int'(pe7); cn7 += int'(ne7); cpc += int'(pcpu); cnc += int'(ncpu);
        end
        total++;
        if ({c14, cp7, cn7, cpc, cnc} !== {32'd16, 32'd8, 32'd8, 32'd4, 32'd4}) begin
            bad++; $display("FAIL run_counts got=%0d/%0d/%0d/%0d/%0d exp=16/8/8/4/4", c14, cp7, cn7, cpc, cnc);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 20 && t_now % 16 != 5; i++) step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL stall_win t=%0d got=%b exp=%b", t_now, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
            if (t_now % 16 == 7) begin
                total++;
                if ({pcpu, ne7} !== 2'b01) begin
                    bad++; $display("FAIL stall_pcpu_drop got pcpu=%b ne7=%b exp pcpu=0 ne7=1", pcpu, ne7);
                end
            end
        end
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL stall_rand t=%0d got=%b exp=%b", t_now, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL lockloss i=%0d got=%b exp=%b", i, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
        end
        total++;
        if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== 6'b0) begin
            bad++; $display("FAIL lockloss_quiet got=%b exp=000000", {sysrst_n, ce14, pe7, ne7, pcpu, ncpu});
        end
        n = 0;
        for (int i = 1; i <= RISE + 20 && n == 0; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL relock cyc=%0d got=%b exp=%b", i, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
            if (sysrst_n === 1'b1) n = i;
        end
        total++;
        if (n != RISE) begin
            bad++; $display("FAIL relock_rise_cycle got=%0d exp=%0d", n, RISE);
        end
    endtask

    task automatic test_async_reset();
        int n;
        total++;
        if (sysrst_n !== 1'b1) begin
            bad++; $display("FAIL async_pre got=%b exp=1", sysrst_n);
        end
        #2 reset = 1'b0;
        #1;
        model_clear();
        total++;
        if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== 6'b0) begin
            bad++; $display("FAIL async_run_clear got=%b exp=000000", {sysrst_n, ce14, pe7, ne7, pcpu, ncpu});
        end
        #1 reset = 1'b1;
        repeat (100) step(1'b1, 1'b0, 2'b00);
        #2 reset = 1'b0;
        #1;
        model_clear();
        total++;
        if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== 6'b0) begin
            bad++; $display("FAIL async_hold_clear got=%b exp=000000", {sysrst_n, ce14, pe7, ne7, pcpu, ncpu});
        end
        #1 reset = 1'b1;
        n = 0;
        for (int i = 1; i <= RISE + 20 && n == 0; i++) begin
            step(1'b1, 1'b0, 2'b00);
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL async_reseq cyc=%0d got=%b exp=%b", i, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
            if (sysrst_n === 1'b1) n = i;
        end
        total++;
        if (n != RISE) begin
            bad++; $display("FAIL async_rise_cycle got=%0d exp=%0d", n, RISE);
        end
    endtask

`ifdef CRS_TURBO_EN
    task automatic test_turbo();
        int cpc;
        for (int m = 1; m <= 2; m++) begin
            step(1'b1, 1'b0, 2'(m));
            cpc = 0;
            for (int i = 0; i < 64; i++) begin
                step(1'b1, 1'b0, 2'(m));
                total++;
                if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                    bad++; $display("FAIL turbo%0d t=%0d got=%b exp=%b", m, t_now, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
                end
                cpc += int'(pcpu);
            end
            total++;
            if (cpc != (m == 1 ? 8 : 16)) begin
                bad++; $display("FAIL turbo%0d_pcpu_count got=%0d exp=%0d", m, cpc, m == 1 ? 8 : 16);
            end
        end
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            total++;
            if ({sysrst_n, ce14, pe7, ne7, pcpu, ncpu} !== exp) begin
                bad++; $display("FAIL turbo_rand t=%0d got=%b exp=%b", t_now, {sysrst_n, ce14, pe7, ne7, pcpu, ncpu}, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_lock_loss();
        test_async_reset();
`ifdef CRS_TURBO_EN
        test_turbo();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
